// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready input, C/Z/N/V flag register and iterative multiply
// Single-cycle ops complete on the accept edge; MUL completes WIDTH edges later
module alu_seq #(
    parameter int WIDTH         = 8,
    parameter bit CIN_FROM_FLAG = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] y,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v,
    output logic             err
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [4:0] OP_MUL = 5'b10010;
    localparam logic [4:0] OP_CMP = 5'b10011;

    typedef enum logic {IDLE, MUL_RUN} state_t;

    state_t               r_state, w_next;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_acc, r_mcand, w_acc_next;
    logic [WIDTH-1:0]     r_mplier, w_r;
    logic [WIDTH:0]       w_sum, w_dif;
    logic                 w_cin, w_c, w_v, w_def, w_add_v, w_sub_v;

    assign in_ready = (r_state == IDLE);
    assign w_cin    = CIN_FROM_FLAG ? flag_c : carry_in;
    // ADC/SBC are the only ops that fold the carry into the adder
    assign w_sum    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (sel == 5'b00001) & w_cin};
    assign w_dif    = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, (sel == 5'b01010) & w_cin};
    assign w_add_v  = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
    assign w_sub_v  = (a[WIDTH-1] != b[WIDTH-1]) && (w_dif[WIDTH-1] != a[WIDTH-1]);
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_comb begin
        w_r   = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_def = 1'b1;
        case (sel)
            5'b00000: w_r = a;
            5'b00001, 5'b00010: begin
                w_r = w_sum[WIDTH-1:0];
                w_c = w_sum[WIDTH];
                w_v = w_add_v;
            end
            5'b00011: w_r = b;
            5'b00100: w_r = a & b;
            5'b00101: w_r = a | b;
            5'b00110: w_r = a ^ b;
            5'b00111: w_r = ~a;
            5'b01000: begin
                w_r = {a[WIDTH-2:0], 1'b0};
                w_c = a[WIDTH-1];
            end
            5'b01001, 5'b01010, OP_CMP: begin
                w_r = w_dif[WIDTH-1:0];
                w_c = w_dif[WIDTH];
                w_v = w_sub_v;
            end
            5'b01011: begin
                w_r = {a[WIDTH-2:0], flag_c};
                w_c = a[WIDTH-1];
            end
            5'b10000: begin
                w_r = {1'b0, a[WIDTH-1:1]};
                w_c = a[0];
            end
            5'b10001: begin
                w_r = {a[WIDTH-1], a[WIDTH-1:1]};
                w_c = a[0];
            end
            OP_MUL, 5'b11000: w_r = '0;
            default: w_def = 1'b0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && in_valid && sel == OP_MUL) w_next = MUL_RUN;
        if (r_state == MUL_RUN && r_cnt == '0) w_next = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y         <= '0;
            flag_c    <= 1'b0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_v    <= 1'b0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
        end else begin
            out_valid <= 1'b0;
            err       <= 1'b0;
            if (r_state == MUL_RUN) begin
                r_acc    <= w_acc_next;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - 1'b1;
                if (r_cnt == '0) begin
                    y         <= w_acc_next[WIDTH-1:0];
                    flag_c    <= |w_acc_next[2*WIDTH-1:WIDTH];
                    flag_z    <= ~|w_acc_next[WIDTH-1:0];
                    flag_n    <= w_acc_next[WIDTH-1];
                    flag_v    <= 1'b0;
                    out_valid <= 1'b1;
                end
            end else if (in_valid) begin
                if (sel == OP_MUL) begin
                    r_acc    <= '0;
                    r_mcand  <= {{WIDTH{1'b0}}, a};
                    r_mplier <= b;
                    r_cnt    <= CW'(WIDTH - 1);
                end else begin
                    out_valid <= 1'b1;
                    err       <= ~w_def;
                    if (!w_def) y <= '0;
                    else begin
                        if (sel != OP_CMP) y <= w_r;
                        flag_c <= w_c;
                        flag_z <= ~|w_r;
                        flag_n <= w_r[WIDTH-1];
                        flag_v <= w_v;
                    end
                end
            end
        end
    end
endmodule
